// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake between uart_rx_param (master) and its consumer (slave).
interface uart_rx_param_if #(
    parameter int N_DATA = 8
);
    logic [N_DATA-1:0] o_data;
    logic              o_valid;
    logic              o_parity_err;
    logic              o_frame_err;
    logic              o_break;
    logic              o_overrun;
    logic              i_ready;

    modport master (
        output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with optional parity, 1-2 stop bits and a one-word output buffer.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote around every sample point.
module uart_rx_param #(
    parameter int N_DATA      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int M_STOP      = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic                   i_rx,
    output logic                   o_busy,
    uart_rx_param_if.master        rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(N_DATA);
    localparam logic [TW-1:0] T_BIT       = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(N_DATA - 1);
    localparam logic [BW-1:0] B_LAST_STOP = BW'(M_STOP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [N_DATA-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              sync1_q, sync2_q, prev_q;
    logic              rx_s, sample;

    logic [N_DATA-1:0] data_q;
    logic              valid_q, perr_out_q, ferr_out_q, brk_out_q, overrun_q;
    logic              load, handshake;

    assign rx_s = sync2_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            if (i_tick) prev_q <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision is one tick late so the vote spans T-1, T, T+1; bit spacing is unchanged.
    localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2);
    logic [1:0] hist_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)    hist_q <= 2'b11;
        else if (i_tick) hist_q <= {hist_q[0], rx_s};
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2 - 1);
    assign sample = rx_s;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (i_tick) begin
            case (state_q)
                IDLE: begin
                    if (prev_q && !rx_s) begin
                        state_d  = START;
                        timer_d  = '0;
                        bitcnt_d = '0;
                        perr_d   = 1'b0;
                        ferr_d   = 1'b0;
                        zero_d   = 1'b1;
                    end
                end
                START: begin
                    if (timer_q == T_START) begin
                        timer_d = '0;
                        state_d = sample ? IDLE : DATA;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DATA: begin
                    if (timer_q == T_BIT) begin
                        timer_d = '0;
                        shift_d = {sample, shift_q[N_DATA-1:1]};
                        if (sample) zero_d = 1'b0;
                        if (bitcnt_q == B_LAST_DATA) begin
                            bitcnt_d = '0;
                            state_d  = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (timer_q == T_BIT) begin
                        timer_d = '0;
                        if (sample) zero_d = 1'b0;
                        // Even: error when total ones is odd; odd: error when it is even.
                        perr_d  = (PARITY_MODE == 1) ? (^shift_q ^ sample) : ~(^shift_q ^ sample);
                        state_d = STOP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                STOP: begin
                    if (timer_q == T_BIT) begin
                        timer_d = '0;
                        if (sample) zero_d = 1'b0;
                        else        ferr_d = 1'b1;
                        if (bitcnt_q == B_LAST_STOP) begin
                            bitcnt_d = '0;
                            state_d  = IDLE;
                            done_d   = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign handshake = valid_q && rx_if.i_ready;
    assign load      = done_q && (!valid_q || rx_if.i_ready);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q     <= shift_q;
                valid_q    <= 1'b1;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_q;
                brk_out_q  <= zero_q;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (handshake)          overrun_q <= 1'b0;
            else if (done_q && !load) overrun_q <= 1'b1;
        end
    end

    assign o_busy             = (state_q != IDLE);
    assign rx_if.o_data       = data_q;
    assign rx_if.o_valid      = valid_q;
    assign rx_if.o_parity_err = perr_out_q;
    assign rx_if.o_frame_err  = ferr_out_q;
    assign rx_if.o_break      = brk_out_q;
    assign rx_if.o_overrun    = overrun_q;
endmodule
